// File: rtl/m1_rate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : m1_rate_ctrl
//  Description : Upstream rate controller for the m1 LED counter. Debounces
//                the two active-low push-buttons and produces a one-cycle
//                tick clock-enable. Key 0 toggles run/pause; key 1 cycles the
//                tick rate while running or single-steps while paused.
//  Revision    : 1.0 - initial release
// ============================================================================
module m1_rate_ctrl #(
    parameter int BASE_DIV        = 50000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] key_n,
    output logic       tick,
    output logic       running,
    output logic [1:0] speed
);

    // Prescaler width covers 0..BASE_DIV-1; debounce counter covers 0..DEBOUNCE_CYCLES-1
    localparam int                c_cnt_w   = $clog2(BASE_DIV);
    localparam int                c_db_w    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        S_PAUSE = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    // One-cycle press pulses, one per key
    logic [1:0] w_press;

    // ------------------------------------------------------------------------
    // Per-key synchronizer, debouncer and press-edge detector
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < 2; g++) begin : g_key
        logic              sync1_q;
        logic              sync2_q;
        logic              deb_q;
        logic              deb_d;
        logic              deb_prev_q;
        logic              press_q;
        logic              press_d;
        logic [c_db_w-1:0] cnt_q;
        logic [c_db_w-1:0] cnt_d;

        // Accept a new level only after it has disagreed with the debounced
        // level for DEBOUNCE_CYCLES consecutive cycles; a press is a 1->0 step
        always_comb begin
            deb_d = deb_q;
            cnt_d = '0;
            if (sync2_q != deb_q) begin
                if (cnt_q == c_db_last) begin
                    deb_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            press_d = deb_prev_q & ~deb_q;
        end

        // Key state registers; released (1) is the idle level
        always_ff @(posedge clk) begin
            if (rst) begin
                sync1_q    <= 1'b1;
                sync2_q    <= 1'b1;
                deb_q      <= 1'b1;
                deb_prev_q <= 1'b1;
                cnt_q      <= '0;
                press_q    <= 1'b0;
            end else begin
                sync1_q    <= key_n[g];
                sync2_q    <= sync1_q;
                deb_q      <= deb_d;
                deb_prev_q <= deb_q;
                cnt_q      <= cnt_d;
                press_q    <= press_d;
            end
        end

        assign w_press[g] = press_q;
    end

    // ------------------------------------------------------------------------
    // Run/pause FSM, speed index and prescaler
    // ------------------------------------------------------------------------
    state_t             state_q;
    state_t             state_d;
    logic [1:0]         speed_q;
    logic [1:0]         speed_d;
    logic [c_cnt_w-1:0] pre_q;
    logic [c_cnt_w-1:0] pre_d;
    logic               tick_q;
    logic               tick_d;
    logic [c_cnt_w-1:0] w_period_m1;
    logic               w_key0;
    logic               w_key1;

    // Terminal prescaler count for the current speed: (BASE_DIV >> speed) - 1
    assign w_period_m1 = c_cnt_w'((BASE_DIV >> speed_q) - 1);

    // key0 wins over a simultaneous key1
    assign w_key0 = w_press[0];
    assign w_key1 = w_press[1] & ~w_press[0];

    // Next state: key handling first, then the prescaler runs only when the
    // next state is RUN, so the entry cycle into PAUSE holds the count and
    // the resume cycle fires any preserved terminal count
    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        pre_d   = pre_q;
        tick_d  = 1'b0;

        if (w_key0) begin
            state_d = (state_q == S_RUN) ? S_PAUSE : S_RUN;
        end

        if (w_key1 && (state_q == S_RUN)) begin
            speed_d = speed_q + 1'b1;
            pre_d   = '0;
        end else if (w_key1) begin
            tick_d  = 1'b1;
        end else if (state_d == S_RUN) begin
            if (pre_q == w_period_m1) begin
                pre_d  = '0;
                tick_d = 1'b1;
            end else begin
                pre_d  = pre_q + 1'b1;
            end
        end
    end

    // Control registers; all outputs come straight from these flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            speed_q <= 2'd0;
            pre_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            speed_q <= speed_d;
            pre_q   <= pre_d;
            tick_q  <= tick_d;
        end
    end

    assign tick    = tick_q;
    assign running = (state_q == S_RUN);
    assign speed   = speed_q;

endmodule
`default_nettype wire

// File: tb/tb_m1_rate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_m1_rate_ctrl
//  Description : Self-checking bench for m1_rate_ctrl (BASE_DIV=16,
//                DEBOUNCE_CYCLES=4) with a cycle-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_m1_rate_ctrl;

    localparam int P_BASE = 16;
    localparam int D      = 4;

    logic       clk;
    logic       rst;
    logic [1:0] key_n;
    logic       tick;
    logic       running;
    logic [1:0] speed;

    m1_rate_ctrl #(
        .BASE_DIV        (P_BASE),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .key_n   (key_n),
        .tick    (tick),
        .running (running),
        .speed   (speed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_print = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            if (n_print < 30) begin
                $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
            end
            n_print++;
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model. Key acceptance is a sliding window: the accepted level
    // flips at edge e when the raw samples taken at edges e-1-D .. e-2 all
    // disagree with it; a 1->0 flip acts on the FSM two edges later. Ticks in
    // RUN fall where the number of running edges since the last restart is a
    // multiple of the period.
    // ------------------------------------------------------------------------
    int e_cnt = 0;
    int hist [2][0:D+1];
    int lvl  [2];
    int due  [2];
    int acc;
    int m_run;
    int m_speed;
    int m_tick;
    int m_started = 0;

    always @(posedge clk) begin
        int p0;
        int p1;
        int restart;
        int nxt_run;
        int allz;
        e_cnt++;
        m_started = 1;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                for (int j = 0; j <= D + 1; j++) hist[k][j] = 1;
                lvl[k] = 1;
                due[k] = -1;
            end
            acc     = 0;
            m_run   = 1;
            m_speed = 0;
            m_tick  = 0;
        end else begin
            p0      = (due[0] == e_cnt) ? 1 : 0;
            p1      = ((due[1] == e_cnt) && (p0 == 0)) ? 1 : 0;
            m_tick  = 0;
            restart = 0;
            nxt_run = m_run;
            if (p0 != 0) begin
                nxt_run = 1 - m_run;
            end else if ((p1 != 0) && (m_run != 0)) begin
                m_speed = (m_speed + 1) % 4;
                restart = 1;
            end else if (p1 != 0) begin
                m_tick = 1;
            end
            if (restart != 0) begin
                acc = 0;
            end else if ((nxt_run != 0) && !((p1 != 0) && (m_run == 0))) begin
                acc++;
                if ((acc % (P_BASE >> m_speed)) == 0) m_tick = 1;
            end
            m_run = nxt_run;
            for (int k = 0; k < 2; k++) begin
                allz = 1;
                for (int j = 1; j <= D; j++) if (hist[k][j] == lvl[k]) allz = 0;
                if (allz != 0) begin
                    lvl[k] = 1 - lvl[k];
                    if (lvl[k] == 0) due[k] = e_cnt + 2;
                end
                for (int j = D + 1; j >= 1; j--) hist[k][j] = hist[k][j-1];
                hist[k][0] = int'(key_n[k]);
            end
        end
    end

    // Every-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (m_started != 0) begin
            check("tick",    int'(tick),    m_tick);
            check("running", int'(running), m_run);
            check("speed",   int'(speed),   m_speed);
        end
    end

    // ------------------------------------------------------------------------
    // Drive a key mask low for `hold` cycles and observe for `span` cycles.
    // lat: first cycle running/speed differ from entry; tf: first tick after
    // that change (relative); t0: first tick cycle; nt: tick count; nchg:
    // number of running/speed changes.
    // ------------------------------------------------------------------------
    task automatic press_measure(input logic [1:0] mask, input int hold, input int span,
                                 output int lat, output int tf, output int nt,
                                 output int t0, output int nchg);
        logic       r_prev;
        logic [1:0] s_prev;
        r_prev = running;
        s_prev = speed;
        lat = -1; tf = -1; nt = 0; t0 = -1; nchg = 0;
        key_n = key_n & ~mask;
        for (int i = 1; i <= span; i++) begin
            @(negedge clk);
            if (i == hold) key_n = key_n | mask;
            if ((running != r_prev) || (speed != s_prev)) begin
                nchg++;
                if (lat < 0) lat = i;
            end
            r_prev = running;
            s_prev = speed;
            if (tick) begin
                nt++;
                if (t0 < 0) t0 = i;
                if ((lat >= 0) && (i > lat) && (tf < 0)) tf = i - lat;
            end
        end
    endtask

    int lat, tf, nt, t0, nchg;
    int tk[3];
    int nidx;
    int hold_left[2];

    initial begin
        rst   = 1'b1;
        key_n = 2'b11;
        repeat (3) @(negedge clk);
        check("reset_tick",    int'(tick),    0);
        check("reset_running", int'(running), 1);
        check("reset_speed",   int'(speed),   0);

        // Free run from reset release
        rst  = 1'b0;
        nidx = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (tick && (nidx < 3)) begin
                tk[nidx] = i;
                nidx++;
            end
        end
        check("free_tick_count", nidx, 3);
        check("free_tick1", tk[0], 16);
        check("free_tick2", tk[1], 32);
        check("free_tick3", tk[2], 48);

        // Speed cycling: 1,2,3,0 with periods 8,4,2,16
        for (int n = 0; n < 4; n++) begin
            press_measure(2'b10, 10, 40, lat, tf, nt, t0, nchg);
            check("speed_latency", lat, 8);
            check("speed_value",   int'(speed), (n + 1) % 4);
            check("speed_first_tick", tf, P_BASE >> ((n + 1) % 4));
        end

        // Pause, idle, three steps, resume
        press_measure(2'b01, 10, 40, lat, tf, nt, t0, nchg);
        check("pause_latency", lat, 8);
        check("pause_running", int'(running), 0);
        nt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tick) nt++;
        end
        check("pause_idle_ticks", nt, 0);
        for (int n = 0; n < 3; n++) begin
            press_measure(2'b10, 10, 40, lat, tf, nt, t0, nchg);
            check("step_tick_count", nt, 1);
            check("step_tick_time",  t0, 8);
            check("step_speed",      int'(speed), 0);
        end
        press_measure(2'b01, 10, 40, lat, tf, nt, t0, nchg);
        check("resume_latency", lat, 8);
        check("resume_running", int'(running), 1);

        // Bounce rejection, then bounce followed by a real hold
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            key_n[0] = (((i / 2) % 2) == 0) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        key_n[0] = 1'b1;
        repeat (30) @(negedge clk);
        check("bounce_running", int'(running), 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            key_n[0] = (((i / 2) % 2) == 0) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        press_measure(2'b01, 30, 40, lat, tf, nt, t0, nchg);
        check("bounce_hold_latency", lat, 8);
        check("bounce_hold_changes", nchg, 1);
        check("bounce_hold_running", int'(running), 0);

        // Simultaneous presses: key0 acts, key1 discarded
        press_measure(2'b11, 10, 40, lat, tf, nt, t0, nchg);
        check("simul1_running", int'(running), 1);
        check("simul1_speed",   int'(speed), 0);
        press_measure(2'b11, 10, 40, lat, tf, nt, t0, nchg);
        check("simul2_running", int'(running), 0);
        check("simul2_speed",   int'(speed), 0);
        check("simul2_no_step", nt, 0);

        // Reach speed 2 in PAUSE, then reset mid-debounce of a key1 press
        press_measure(2'b01, 10, 40, lat, tf, nt, t0, nchg);
        press_measure(2'b10, 10, 40, lat, tf, nt, t0, nchg);
        press_measure(2'b10, 10, 40, lat, tf, nt, t0, nchg);
        press_measure(2'b01, 10, 40, lat, tf, nt, t0, nchg);
        check("pre_rst_speed",   int'(speed), 2);
        check("pre_rst_running", int'(running), 0);
        key_n[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst      = 1'b1;
        key_n[1] = 1'b1;
        @(negedge clk);
        check("midrst_running", int'(running), 1);
        check("midrst_speed",   int'(speed), 0);
        check("midrst_tick",    int'(tick), 0);
        rst = 1'b0;
        t0  = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (tick && (t0 < 0)) t0 = i;
        end
        check("midrst_first_tick", t0, 16);

        // Randomized keys with occasional reset
        hold_left[0] = 0;
        hold_left[1] = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (hold_left[k] == 0) begin
                    key_n[k]     = ($urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
                    hold_left[k] = $urandom_range(1, 14);
                end else begin
                    hold_left[k]--;
                end
            end
            rst = ($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0;
        end
        rst   = 1'b0;
        key_n = 2'b11;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/m1_rate_ctrl.md
# m1_rate_ctrl

Upstream rate controller for the m1 LED counter. It debounces the two DE0-Nano push-buttons and generates a one-cycle `tick` clock-enable that advances the counter. Key 0 toggles run/pause. Key 1 cycles the tick rate while running, or single-steps the counter while paused. It replaces the fixed clkdiv stage, so the counter runs on `sys_clk` gated by `tick`.

## Interface
- `BASE_DIV`, default 50000000: tick period in clk cycles at speed 0. Must be a multiple of 8 and ≥ 8.
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a key level (20 ms at 50 MHz). Must be ≥ 1.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `key_n`  in  2  raw push-buttons, active-low, asynchronous to `clk`.
- `tick`  out  1  one-cycle clock-enable pulse for the counter.
- `running`  out  1  1 = RUN, 0 = PAUSE.
- `speed`  out  2  current rate index, 0..3.

## Operation
- Reset values: `tick` = 0, `running` = 1 (RUN), `speed` = 0, prescaler = 0.
  - Synchronizer and debounced key state reset to 1 (released); debounce counters reset to 0.
- Synchronizer: two flops per key.
- Debounce, per key:
  - A counter counts while the synchronized level differs from the debounced level.
  - Any cycle where they match clears the counter.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level takes the synchronized value and the counter clears.
- Press event: registered one-cycle pulse on a debounced 1→0 transition. Releases generate no event.
- FSM, states RUN and PAUSE:
  - key0 press: RUN→PAUSE or PAUSE→RUN.
  - key1 press in RUN: `speed` ← (`speed`+1) mod 4 (3 wraps to 0); prescaler cleared to 0.
  - key1 press in PAUSE: exactly one `tick` pulse on the next cycle; `speed` and prescaler unchanged.
  - key0 and key1 press in the same cycle: key0 acts; key1 is discarded.
- Prescaler:
  - Period P = `BASE_DIV` >> `speed`, i.e. `BASE_DIV`, /2, /4 or /8.
  - In RUN it counts 0..P−1. `tick` is asserted for the cycle after the count reaches P−1, and the count wraps to 0.
  - In PAUSE the count holds its value; RUN resumes from the held value.
- Counter width: $clog2(`BASE_DIV`). All outputs are registered.

## Timing
- Key latency: let N be the first edge where the raw `key_n` bit is sampled low, held low throughout.
  - Debounced level changes at edge N+1+`DEBOUNCE_CYCLES`.
  - Press pulse is high after edge N+2+`DEBOUNCE_CYCLES`.
  - `running`/`speed` update at edge N+3+`DEBOUNCE_CYCLES`.
- Bounce: any raw glitch shorter than `DEBOUNCE_CYCLES` cycles after synchronization produces no event.
- Step tick: `tick` is high for exactly the cycle after the FSM update edge, at most one per press.
- RUN tick cadence:
  - After reset release, the first `tick` is high in cycle P (cycles numbered from 1).
  - Thereafter ticks are exactly P cycles apart.
- Speed change: the prescaler restarts from 0 at the update edge; the next tick arrives P_new cycles later. Any tick due on the update edge is suppressed.
- Pause: the first PAUSE cycle has `tick` = 0 even if the prescaler was at P−1. That terminal count is preserved and fires on the first RUN cycle after resume.
- Held key: one event per press, regardless of hold length.
- `rst` mid-operation forces all reset values on the next edge, discards in-flight debounce progress, and cancels any pending step tick.

## Test plan
All scenarios use `BASE_DIV`=16, `DEBOUNCE_CYCLES`=4.
- **Reset and free run:** reset, then idle keys → `running`=1, `speed`=0, `tick` high in cycles 16, 32, 48; never two consecutive highs.
- **Speed cycling:** four clean key1 presses in RUN → `speed` 1, 2, 3, 0. Tick period 8, 4, 2, 16; first tick after each change is P_new cycles after the update edge.
- **Pause and step:** key0 press, then `tick` stays 0 for 100 cycles. Three key1 presses → exactly three single-cycle ticks, each 1 cycle after its FSM update; `speed` unchanged. key0 press → RUN resumes from the held prescaler count.
- **Bounce rejection:** key0 toggling every 2 cycles for 20 cycles, then released → no state change. Same toggling then held low → exactly one toggle at N+7 from the final low edge.
- **Simultaneous presses:** key0 and key1 driven low on the same edge → `running` toggles; `speed` unchanged; no step tick.
- **Reset mid-operation:** `rst` at `speed`=2 in PAUSE with a key1 press mid-debounce → next cycle `running`=1, `speed`=0, `tick`=0. No step tick ever; first tick 16 cycles after reset release.
